// File: rtl/instr_cache_pkg.sv
// Shared types, constants and address-split helpers for the instruction cache.
package instr_cache_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {LOOKUP, FILL} icache_state_t;

    // Field extractors return the field right-aligned; callers cast to the field width.
    function automatic logic [31:0] addr_off(logic [31:0] pc, int unsigned off_w);
        return (pc >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(logic [31:0] pc, int unsigned off_w,
                                             int unsigned idx_w);
        return (pc >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(logic [31:0] pc, int unsigned off_w,
                                             int unsigned idx_w);
        return pc >> (2 + off_w + idx_w);
    endfunction

endpackage

// File: rtl/instr_memory_if.sv
// Instruction-fetch interface: the requester drives pc, the provider returns instr.
interface instr_memory_if;
    logic [31:0] pc;
    logic [31:0] instr;

    modport provider (input pc, output instr);
    modport requester (output pc, input instr);
endinterface

// File: rtl/icache_data_ram.sv
// Cache data array: asynchronous read, synchronous write, no reset.
module icache_data_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with in-order whole-line refill over a
// req/ack word port. Hits return the instruction in the same cycle as the pc.
module instr_cache #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP_INSTR  = instr_cache_pkg::NOP_INSTR
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    instr_memory_if.provider        imem_if,
    output logic                    stall_o,
    input  logic                    flush_i,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [31:0]             mem_rdata_i
);
    import instr_cache_pkg::*;

    localparam int unsigned OffW = $clog2(LINE_WORDS);
    localparam int unsigned IdxW = $clog2(NUM_LINES);
    localparam int unsigned TagW = 30 - OffW - IdxW;

    logic [OffW-1:0]      off;
    logic [IdxW-1:0]      idx;
    logic [TagW-1:0]      tag;

    icache_state_t        state_q;
    logic [OffW-1:0]      cnt_q;
    logic [OffW-1:0]      cnt_d;
    logic [TagW-1:0]      miss_tag_q;
    logic [IdxW-1:0]      miss_idx_q;
    logic                 mem_req_q;
    logic [31:0]          mem_addr_q;
    logic                 flush_pending_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TagW-1:0]      tag_q [NUM_LINES];

    logic                 hit;
    logic                 fill_ack;
    logic                 last_ack;
    logic [31:0]          ram_rdata;

    assign off = OffW'(addr_off(imem_if.pc, OffW));
    assign idx = IdxW'(addr_idx(imem_if.pc, OffW, IdxW));
    assign tag = TagW'(addr_tag(imem_if.pc, OffW, IdxW));

    assign hit      = (state_q == LOOKUP) && valid_q[idx] && (tag_q[idx] == tag);
    assign fill_ack = (state_q == FILL) && mem_req_q && mem_ack_i;
    assign last_ack = fill_ack && (cnt_q == OffW'(LINE_WORDS - 1));
    assign cnt_d    = cnt_q + OffW'(1);

    assign stall_o       = !hit;
    assign imem_if.instr = hit ? ram_rdata : NOP_INSTR;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;

    icache_data_ram #(
        .Depth (NUM_LINES * LINE_WORDS),
        .Width (32)
    ) u_data_ram (
        .clk_i   (clk_i),
        .we_i    (fill_ack),
        .waddr_i ({miss_idx_q, cnt_q}),
        .wdata_i (mem_rdata_i),
        .raddr_i ({idx, off}),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= LOOKUP;
            cnt_q           <= '0;
            miss_tag_q      <= '0;
            miss_idx_q      <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            flush_pending_q <= 1'b0;
            valid_q         <= '0;
        end else begin
            unique case (state_q)
                LOOKUP: begin
                    // The hit seen this cycle stands even when a flush lands on this edge.
                    if (flush_i) begin
                        valid_q <= '0;
                    end
                    if (!hit) begin
                        miss_tag_q <= tag;
                        miss_idx_q <= idx;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {tag, idx, {OffW{1'b0}}, 2'b00};
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (fill_ack) begin
                        cnt_q      <= cnt_d;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, cnt_d, 2'b00};
                    end
                    if (last_ack) begin
                        mem_req_q       <= 1'b0;
                        flush_pending_q <= 1'b0;
                        state_q         <= LOOKUP;
                        // A fence seen at any point of the fill invalidates everything,
                        // including the line just fetched.
                        if (flush_pending_q || flush_i) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[miss_idx_q] <= 1'b1;
                        end
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (last_ack) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: line-level cache model checked every cycle,
// plus directed scenarios with hand-computed stall counts and data words.
`timescale 1ns/1ps
module tb_instr_cache;

    localparam int unsigned NL  = 16;
    localparam int unsigned LW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;

    instr_memory_if imem ();

    instr_cache #(
        .NUM_LINES  (NL),
        .LINE_WORDS (LW),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .imem_if     (imem),
        .stall_o     (stall),
        .flush_i     (flush),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (ack),
        .mem_rdata_i (rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: acks each request after an optional per-address delay.
    logic [31:0] dly_addr = 32'hFFFF_FFFF;
    int          dly_cycles = 0;
    int          wcnt = 0;
    bit          force_ack = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (force_ack) begin
            ack   = 1'b1;
            rdata = 32'hDEAD_BEEF;
        end else if (ack) begin
            ack = 1'b0;
        end else if (mem_req) begin
            if (mem_addr == dly_addr && wcnt < dly_cycles) begin
                wcnt++;
            end else begin
                ack   = 1'b1;
                rdata = mem_word(mem_addr);
                wcnt  = 0;
            end
        end
    end

    // Line-level model: which lines are resident, and the fill in progress.
    bit          m_valid [NL];
    logic [31:0] m_tag [NL];
    bit          m_busy = 1'b0;
    bit          m_fl = 1'b0;
    logic [31:0] m_base;
    int unsigned m_idx;
    logic [31:0] m_tagv;
    int          m_k;
    int unsigned li;
    logic [31:0] lt;
    bit          lhit;
    bit          run = 1'b0;
    logic [31:0] acked_q [$];

    always @(negedge clk) begin
        #2;
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 1'b0;
            m_fl   = 1'b0;
        end else if (run) begin
            if (!m_busy) begin
                li   = (imem.pc / (4 * LW)) % NL;
                lt   = imem.pc / (4 * LW * NL);
                lhit = m_valid[li] && (m_tag[li] == lt);
                chk("lookup stall", {31'b0, stall}, {31'b0, !lhit});
                chk("lookup instr", imem.instr, lhit ? mem_word(imem.pc) : NOP);
                chk("lookup mem_req", {31'b0, mem_req}, 32'd0);
                if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
                if (!lhit) begin
                    m_busy = 1'b1;
                    m_fl   = 1'b0;
                    m_base = imem.pc - (imem.pc % (4 * LW));
                    m_idx  = li;
                    m_tagv = lt;
                    m_k    = 0;
                end
            end else begin
                chk("fill stall", {31'b0, stall}, 32'd1);
                chk("fill instr", imem.instr, NOP);
                chk("fill mem_req", {31'b0, mem_req}, 32'd1);
                chk("fill mem_addr", mem_addr, m_base + 32'(4 * m_k));
                if (flush) m_fl = 1'b1;
                if (ack) begin
                    acked_q.push_back(mem_addr);
                    m_k++;
                    if (m_k == LW) begin
                        if (m_fl) begin
                            foreach (m_valid[i]) m_valid[i] = 1'b0;
                        end else begin
                            m_valid[m_idx] = 1'b1;
                            m_tag[m_idx]   = m_tagv;
                        end
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Called right after a negedge drive; returns inside the first non-stalled cycle.
    task automatic wait_hit(input int max_cycles, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            #3;
            if (!stall) done = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_hit timeout: stall still %b after %0d cycles", stall, max_cycles);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int exp_stalls, input string name);
        int n;
        @(negedge clk);
        imem.pc = pc;
        wait_hit(60, n);
        chk({name, " stall cycles"}, n, exp_stalls);
        chk({name, " instr"}, imem.instr, mem_word(pc));
    endtask

    logic [31:0] hit_pc [3] = '{32'h4, 32'h8, 32'hE};
    logic [31:0] hit_dat [3] = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
    logic [31:0] exp_addr [8] = '{32'h40, 32'h44, 32'h48, 32'h4C,
                                  32'h40, 32'h44, 32'h48, 32'h4C};
    int b;
    int n;

    initial begin
        imem.pc = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset stall", {31'b0, stall}, 32'd1);
        chk("reset instr", imem.instr, NOP);

        // Cold miss: 1 lookup + 7 fill cycles (ack, idle, ack, ...)
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        imem.pc = 32'h0;
        wait_hit(60, n);
        chk("cold stall cycles", n, 8);
        chk("cold instr", imem.instr, 32'h1000_0000);
        for (int i = 0; i < 4; i++) chk("cold mem_addr seq", acked_q[i], 32'(4 * i));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem.pc = hit_pc[i];
            #3;
            chk("line hit stall", {31'b0, stall}, 32'd0);
            chk("line hit instr", imem.instr, hit_dat[i]);
            chk("line hit mem_req", {31'b0, mem_req}, 32'd0);
        end

        // Flush in lookup: this cycle's hit stands, the next one misses.
        @(negedge clk);
        imem.pc = 32'h0;
        flush = 1'b1;
        #3;
        chk("flush-cycle hit", {31'b0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        wait_hit(60, n);
        chk("after flush stall cycles", n, 8);

        fetch(32'h100, 8, "conflict");
        chk("conflict instr literal", imem.instr, 32'h1000_0040);
        for (int i = 0; i < 4; i++)
            chk("conflict mem_addr", acked_q[acked_q.size() - 4 + i], 32'h100 + 32'(4 * i));
        fetch(32'h0, 8, "evicted refetch");

        dly_addr   = 32'h208;
        dly_cycles = 5;
        fetch(32'h200, 13, "backpressure");
        chk("backpressure instr literal", imem.instr, 32'h1000_0080);
        for (int i = 0; i < 4; i++)
            chk("backpressure mem_addr", acked_q[acked_q.size() - 4 + i], 32'h200 + 32'(4 * i));
        dly_addr = 32'hFFFF_FFFF;

        // Flush after the 2nd ack of a fill at 0x40.
        fetch(32'h0, 8, "revalidate 0x0");
        b = acked_q.size();
        @(negedge clk);
        imem.pc = 32'h40;
        for (int i = 0; i < 40 && acked_q.size() < b + 2; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_hit(60, n);
        chk("flush-fill instr", imem.instr, 32'h1000_0010);
        chk("flush-fill ack count", acked_q.size(), b + 8);
        for (int i = 0; i < 8; i++) chk("flush-fill mem_addr", acked_q[b + i], exp_addr[i]);
        fetch(32'h0, 8, "flushed 0x0 misses");

        // Reset between the 1st and 2nd ack of a fill.
        b = acked_q.size();
        @(negedge clk);
        imem.pc = 32'h300;
        for (int i = 0; i < 40 && acked_q.size() < b + 1; i++) @(negedge clk);
        #1;
        chk("mem_req before reset", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async mem_req drop", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem.pc = 32'h0;
        wait_hit(60, n);
        chk("post-reset miss stall cycles", n, 8);

        fetch(32'hFFFF_FFFC, 8, "wrap");
        chk("wrap instr literal", imem.instr, 32'h4FFF_FFFF);

        // Spurious ack while idle must not disturb the hit line.
        @(posedge clk);
        #1 force_ack = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("spurious ack instr", imem.instr, 32'h4FFF_FFFF);

        @(negedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
